ks_addsub16_pipe: RTL and testbench
===================================

// Module: ks_addsub16_pipe
// PURPOSE
//  Pipelined 16-bit Kogge-Stone adder/subtractor with valid/ready handshake on both sides.
//  - op=1 (subtract): computes A - B as A + ~B + 1. op=0 (add): computes A + B.
//  - Sits between the operand staging logic and the ALU result mux.
//  - Gives the carry-prefix network a registered, back-pressurable datapath, replacing the
//    purely combinational prefix layers.
// PARAMETERS
//  WIDTH   16  operand width; fixed at 16, since the prefix network is log2(16)=4 levels + PG generation
//  STAGES  3   pipeline depth; fixed; documents latency
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operand beat valid
//  in_ready   out  1   block can accept operand beat this cycle
//  in_a       in   16  minuend / addend A
//  in_b       in   16  subtrahend / addend B
//  in_op      in   1   0=add, 1=subtract
//  out_valid  out  1   result beat valid
//  out_ready  in   1   consumer accepts result this cycle
//  out_sum    out  16  A+B or A-B, mod 2^16
//  out_carry  out  1   carry-out; for subtract, 1 = no borrow (A>=B unsigned)
//  out_ovf    out  1   signed two's-complement overflow
//  out_zero   out  1   out_sum == 0
// BEHAVIOUR
//  - Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer when out_valid & out_ready.
//  - Stage S1: computes b' = in_op ? ~in_b : in_b, with cin = in_op.
//    - p[i] = a^b', g[i] = a&b'; bit 0 folds cin: g0 = a0&b'0 | p0&cin.
//    - Registers p, g, a[15], b'[15] and valid.
//  - Stage S2: prefix levels dist 1 and 2 (G = Gi | Pi&Gi-d, P = Pi&Pi-d); registers G, P, the original p, sign bits and valid.
//  - Stage S3: prefix levels dist 4 and 8.
//    - sum[0] = p0^cin; sum[i] = p[i]^G[i-1]; carry = G[15].
//    - ovf = (a15 == b'15) & (sum15 != a15); zero = ~|sum.
//    - Registers outputs and valid.
//  - Positions below the combine distance pass through unchanged at every level.
//  - Latency: exactly 3 cycles from input transfer to out_valid with no stall; throughput 1 beat per cycle.
//  - Elastic pipeline: stage k loads when !valid_k | (advance of stage k+1). S3 advances on out_ready.
//    - in_ready = !valid_S1 | advance_S1 (combinational through the chain, no skid buffer).
//    - Bubbles collapse: an empty stage accepts while downstream is stalled.
//  - While out_valid & !out_ready: out_sum, out_carry, out_ovf and out_zero hold stable and no beat is lost or duplicated.
//  - Beats leave in order. An input transfer and an output transfer in the same cycle are both legal when full.
//  - Reset: all valid bits 0; out_sum, out_carry, out_ovf, out_zero = 0; in_ready = 1 in the first cycle after reset.
//    - Reset mid-stream drops all in-flight beats; no output transfer occurs on the reset cycle.
//  - Data registers may be left unreset internally, but the output registers are reset.
//  - Wrap-around: 0xFFFF + 0x0001 -> sum 0x0000, carry 1, zero 1.
//  - Unsigned interpretation is out_carry; signed interpretation is out_ovf; both are valid for both ops.
// STRUCTURE
//  - Shared package ks_pkg:
//    - localparams KS_WIDTH=16, KS_LEVELS=4, KS_STAGES=3
//    - typedef logic [15:0] ks_word_t
//    - typedef struct {ks_word_t g, p;} ks_gp_t
//    - enum ks_op_e {KS_ADD=0, KS_SUB=1}
//  - One sub-module: ks_prefix_level #(DIST).
//    - Combinational Kogge-Stone combine at distance DIST, with pass-through below DIST.
//    - Instantiated 4 times (DIST=1,2,4,8), two per pipeline stage.
//  - Top level holds PG generation, the three register banks, the valid/ready chain and the sum/flag logic.
// TESTING
//  - Sub, no stall: A=0x0005, B=0x0003, op=1 -> after 3 clk: sum 0x0002, carry 1, ovf 0, zero 0.
//  - Borrow: A=0x0003, B=0x0005, op=1 -> sum 0xFFFE, carry 0, ovf 0.
//  - Signed overflow: A=0x7FFF, B=0x0001, op=0 -> sum 0x8000, ovf 1, carry 0.
//    - A=0x8000, B=0x0001, op=1 -> sum 0x7FFF, ovf 1, carry 1.
//  - Wrap/zero: A=0xFFFF, B=0x0001, op=0 -> sum 0x0000, carry 1, zero 1.
//    - A=0x1234, B=0x1234, op=1 -> sum 0, carry 1, zero 1.
//  - Back-pressure: stream 6 beats with out_ready=0 for cycles 4-8.
//    - in_ready drops after 3 accepted beats.
//    - Outputs hold stable; all 6 results emerge in order after release.
//  - Reset mid-stream: assert rst with 2 beats in flight -> out_valid 0 next cycle, in_ready 1, no stale result emitted.
//  - Random: 10k constrained-random beats with random in_valid/out_ready, compared against a reference model of {carry, sum} = A + (op ? ~B : B) + op.

Source files
------------

// File: rtl/ks_addsub16_pipe_pkg.sv
// Shared types and constants for the pipelined Kogge-Stone adder/subtractor.
package ks_pkg;
  localparam int KS_WIDTH  = 16;
  localparam int KS_LEVELS = 4;
  localparam int KS_STAGES = 3;

  typedef logic [KS_WIDTH-1:0] ks_word_t;

  typedef struct packed {
    ks_word_t g;
    ks_word_t p;
  } ks_gp_t;

  typedef enum logic {KS_ADD = 1'b0, KS_SUB = 1'b1} ks_op_e;
endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone combine level at distance DIST; bits below DIST pass through.
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int DIST = 1
) (
  input  ks_gp_t i_gp,
  output ks_gp_t o_gp
);
  ks_word_t w_g, w_p;

  for (genvar i = 0; i < KS_WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_comb
      assign w_g[i] = i_gp.g[i] | (i_gp.p[i] & i_gp.g[i-DIST]);
      assign w_p[i] = i_gp.p[i] & i_gp.p[i-DIST];
    end else begin : g_pass
      assign w_g[i] = i_gp.g[i];
      assign w_p[i] = i_gp.p[i];
    end
  end

  assign o_gp = '{g: w_g, p: w_p};
endmodule

// File: rtl/ks_addsub16_pipe.sv
// 3-stage elastic Kogge-Stone add/sub: PG gen | prefix d1,d2 | prefix d4,d8 + sum/flags.
module ks_addsub16_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH  = KS_WIDTH,
  parameter int STAGES = KS_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);
  logic [STAGES:1] r_vld;
  logic [STAGES:1] w_load;

  // Stage k loads when empty or when its downstream neighbour moves.
  assign w_load[STAGES] = !r_vld[STAGES] | out_ready;
  for (genvar k = 1; k < STAGES; k++) begin : g_load
    assign w_load[k] = !r_vld[k] | w_load[k+1];
  end
  assign in_ready  = w_load[1];
  assign out_valid = r_vld[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      if (w_load[1]) r_vld[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++)
        if (w_load[k]) r_vld[k] <= r_vld[k-1];
    end
  end

  // S1: PG generation with carry-in folded into g[0]
  ks_op_e   w_op;
  logic     w_cin;
  ks_word_t w_b;
  ks_gp_t   w_gp0;

  always_comb begin
    w_op       = ks_op_e'(in_op);
    w_cin      = (w_op == KS_SUB);
    w_b        = w_cin ? ~in_b : in_b;
    w_gp0.p    = in_a ^ w_b;
    w_gp0.g    = in_a & w_b;
    w_gp0.g[0] = (in_a[0] & w_b[0]) | (w_gp0.p[0] & w_cin);
  end

  ks_gp_t r1_gp;
  logic   r1_a15, r1_b15, r1_cin;

  always_ff @(posedge clk) begin
    if (w_load[1] && in_valid) begin
      r1_gp  <= w_gp0;
      r1_a15 <= in_a[WIDTH-1];
      r1_b15 <= w_b[WIDTH-1];
      r1_cin <= w_cin;
    end
  end

  // S2: prefix levels at distance 1 and 2
  ks_gp_t w_gp1, w_gp2;
  ks_prefix_level #(.DIST(1)) u_lvl1 (.i_gp(r1_gp), .o_gp(w_gp1));
  ks_prefix_level #(.DIST(2)) u_lvl2 (.i_gp(w_gp1), .o_gp(w_gp2));

  ks_gp_t   r2_gp;
  ks_word_t r2_p;
  logic     r2_a15, r2_b15, r2_cin;

  always_ff @(posedge clk) begin
    if (w_load[2] && r_vld[1]) begin
      r2_gp  <= w_gp2;
      r2_p   <= r1_gp.p;
      r2_a15 <= r1_a15;
      r2_b15 <= r1_b15;
      r2_cin <= r1_cin;
    end
  end

  // S3: prefix levels at distance 4 and 8, then sum and flags
  ks_gp_t w_gp4, w_gp8;
  ks_prefix_level #(.DIST(4)) u_lvl4 (.i_gp(r2_gp), .o_gp(w_gp4));
  ks_prefix_level #(.DIST(8)) u_lvl8 (.i_gp(w_gp4), .o_gp(w_gp8));

  ks_word_t w_sum;
  logic     w_carry, w_ovf;
  logic     w_unused_p;

  // G[i-1] is the carry into bit i because cin already sits in g[0].
  assign w_sum      = r2_p ^ {w_gp8.g[WIDTH-2:0], r2_cin};
  assign w_carry    = w_gp8.g[WIDTH-1];
  assign w_ovf      = (r2_a15 == r2_b15) & (w_sum[WIDTH-1] != r2_a15);
  assign w_unused_p = &{1'b0, w_gp8.p};

  logic [WIDTH-1:0] r_sum;
  logic             r_carry, r_ovf, r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_load[STAGES] && r_vld[STAGES-1]) begin
      r_sum   <= w_sum;
      r_carry <= w_carry;
      r_ovf   <= w_ovf;
      r_zero  <= ~|w_sum;
    end
  end

  assign out_sum   = r_sum;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;
endmodule

// File: tb/tb_ks_addsub16_pipe.sv
// Scoreboard bench for ks_addsub16_pipe: directed corners, stall, mid-stream reset, random.
module tb_ks_addsub16_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_op;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready;
  logic [15:0] out_sum;
  logic        out_carry, out_ovf, out_zero;

  int          checks = 0;
  int          errors = 0;
  logic [18:0] exp_q[$];

  ks_addsub16_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  // Expected {carry, ovf, zero, sum}; overflow from true signed arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
    logic [16:0] r;
    int          sa, sb, sr;
    logic        ovf;
    r   = {1'b0, a} + {1'b0, (op ? ~b : b)} + {16'd0, op};
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sr  = op ? (sa - sb) : (sa + sb);
    ovf = (sr > 32767) || (sr < -32768);
    return {r[16], ovf, (r[15:0] == 16'd0), r[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic op, input logic ordy, output logic acc);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(a, b, op));
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset_sum got %h exp 0000", out_sum); end
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b exp 0", out_carry); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", out_ovf); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", out_zero); end
  endtask

  task automatic test_directed();
    logic [15:0] ta[6], tbv[6];
    logic        top[6];
    logic [18:0] te[6];
    int          lat;
    ta  = '{16'h0005, 16'h0003, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234};
    tbv = '{16'h0003, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h1234};
    top = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    te  = '{{3'b100, 16'h0002}, {3'b000, 16'hFFFE}, {3'b010, 16'h8000},
            {3'b110, 16'h7FFF}, {3'b101, 16'h0000}, {3'b101, 16'h0000}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = ta[i]; in_b = tbv[i]; in_op = top[i]; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b exp 1", i, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
      checks++; if (lat != 3) begin errors++; $display("FAIL dir%0d_latency got %0d exp 3", i, lat); end
      checks++;
      if ({out_carry, out_ovf, out_zero, out_sum} !== te[i]) begin
        errors++; $display("FAIL dir%0d_result got %h exp %h", i, {out_carry, out_ovf, out_zero, out_sum}, te[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int          n_in, n_out;
    logic        acc;
    logic [18:0] e;
    exp_q.delete();
    n_in = 0; n_out = 0;
    for (int c = 0; c < 60 && n_out < 6; c++) begin
      @(negedge clk);
      drive(n_in < 6, 16'h1111 * 16'(n_in + 1), 16'h0203 * 16'(n_in), 1'(n_in % 2), (c > 8), acc);
      if (acc) n_in++;
      if (c == 3) begin
        checks++; if (n_in != 3) begin errors++; $display("FAIL bp_accepted got %0d exp 3", n_in); end
      end
      if (c >= 3 && c <= 8) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b exp 0", c, in_ready); end
        checks++;
        if (out_valid !== 1'b1 || {out_carry, out_ovf, out_zero, out_sum} !== exp_q[0]) begin
          errors++; $display("FAIL bp_hold c%0d got v%b %h exp v1 %h", c, out_valid, {out_carry, out_ovf, out_zero, out_sum}, exp_q[0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra got unexpected beat %h exp none", out_sum);
        end else begin
          e = exp_q.pop_front();
          n_out++;
          if ({out_carry, out_ovf, out_zero, out_sum} !== e) begin
            errors++; $display("FAIL bp_order got %h exp %h", {out_carry, out_ovf, out_zero, out_sum}, e);
          end
        end
      end
    end
    checks++; if (n_out != 6) begin errors++; $display("FAIL bp_drain got %0d exp 6", n_out); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic acc;
    exp_q.delete();
    @(negedge clk); drive(1'b1, 16'hAAAA, 16'h1111, 1'b0, 1'b1, acc);
    @(negedge clk); drive(1'b1, 16'h5555, 16'h2222, 1'b1, 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_cycle_out_valid got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstm_stale c%0d got %b exp 0", c, out_valid); end
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int          n_in, cyc;
    logic        acc;
    logic [18:0] e;
    logic [15:0] a, b;
    exp_q.delete();
    n_in = 0; cyc = 0;
    while ((n_in < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      a = pick(); b = pick();
      drive((n_in < 10000) && ($urandom_range(3) != 0), a, b, 1'($urandom_range(1)),
            ($urandom_range(3) != 0), acc);
      if (acc) n_in++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra got beat %h exp none", out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_carry, out_ovf, out_zero, out_sum} !== e) begin
            errors++; $display("FAIL rand_result got %h exp %h", {out_carry, out_ovf, out_zero, out_sum}, e);
          end
        end
      end
    end
    checks++;
    if (n_in != 10000 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_timeout got in=%0d pending=%0d exp in=10000 pending=0", n_in, exp_q.size());
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
